// File: rtl/pio_blink_sequencer.sv
// Avalon-MM sequencer that replays a bit pattern into a 1-bit LED PIO, one bit per period,
// while letting host "manual" writes pre-empt the sequence without losing either request.
module pio_blink_sequencer #(
  parameter int PATTERN_LEN = 8,
  parameter int PERIOD_W    = 32,
  parameter int PERIOD_RST  = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic [7:0]  step
);

  localparam int         IDX_W     = $clog2(PATTERN_LEN);
  localparam logic [7:0] LAST_STEP = 8'(PATTERN_LEN - 1);

  logic                   enable;
  logic                   one_shot;
  logic                   done;
  logic                   last;
  logic                   tick_pend;
  logic                   man_pend;
  logic                   man_val;
  logic                   pio_bit;
  logic [PERIOD_W-1:0]    period;
  logic [PERIOD_W-1:0]    counter;
  logic [PATTERN_LEN-1:0] pattern;

  logic                host_wr;
  logic [PERIOD_W-1:0] period_m1;
  logic                wrap;
  logic                pat_bit;
  logic                issue_man;
  logic                issue_tick;
  logic                finish;

  assign host_wr    = chipselect & ~write_n;
  assign period_m1  = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign wrap       = enable && (counter == period_m1);
  assign pat_bit    = pattern[step[IDX_W-1:0]];
  assign issue_man  = man_pend;
  assign issue_tick = ~man_pend & tick_pend;
  assign finish     = issue_tick & one_shot & (step == LAST_STEP);

  // PIO strobe: pio_chipselect is a one-cycle pulse, pio_write_n is low exactly in that
  // cycle, and pio_writedata is stable alongside it; the slave has no wait states.
  assign pio_address   = 2'b00;
  assign pio_writedata = {31'b0, pio_bit};

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[2:0] = {done, one_shot, enable};
      2'd1:    readdata = 32'(period);
      2'd2:    readdata = 32'(pattern);
      default: readdata = {16'b0, step, 5'b0, last, done, man_pend | tick_pend};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable         <= 1'b0;
      one_shot       <= 1'b0;
      done           <= 1'b0;
      last           <= 1'b0;
      tick_pend      <= 1'b0;
      man_pend       <= 1'b0;
      man_val        <= 1'b0;
      pio_bit        <= 1'b0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      period         <= PERIOD_W'(PERIOD_RST);
      counter        <= '0;
      pattern        <= '0;
      step           <= 8'd0;
    end else begin
      pio_chipselect <= issue_man | issue_tick;
      pio_write_n    <= ~(issue_man | issue_tick);

      if (issue_man) begin
        pio_bit  <= man_val;
        last     <= man_val;
        man_pend <= 1'b0;
      end else if (issue_tick) begin
        pio_bit   <= pat_bit;
        last      <= pat_bit;
        tick_pend <= 1'b0;
        step      <= (step == LAST_STEP) ? 8'd0 : step + 8'd1;
      end

      // The final one-shot bit consumes the shot; a coincident wrap must not queue a tick.
      if (finish) begin
        enable   <= 1'b0;
        one_shot <= 1'b0;
        done     <= 1'b1;
      end

      if (wrap) begin
        counter <= '0;
        if (!finish) tick_pend <= 1'b1;
      end else if (enable) begin
        counter <= counter + PERIOD_W'(1);
      end

      // Host writes come last so they win over the sequencer's own updates.
      if (host_wr) begin
        case (address)
          2'd0: begin
            one_shot <= writedata[1];
            if (writedata[0] && !enable) begin
              enable    <= 1'b1;
              counter   <= '0;
              step      <= 8'd0;
              done      <= 1'b0;
              tick_pend <= 1'b1;
            end else if (!writedata[0] && enable) begin
              enable    <= 1'b0;
              tick_pend <= 1'b0;
            end
          end
          2'd1: begin
            period <= PERIOD_W'(writedata);
            if (enable) counter <= '0;
          end
          2'd2: pattern <= PATTERN_LEN'(writedata);
          default: begin
            man_pend <= 1'b1;
            man_val  <= writedata[0];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pio_blink_sequencer.sv
// Directed-sequence bench for pio_blink_sequencer: strobes are logged with their cycle and
// compared against a schedule computed from period/pattern arithmetic.
module tb_pio_blink_sequencer;

  localparam int LEN  = 8;
  localparam int PRST = 50000000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [7:0]  step;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int last_wr_cyc;

  // Entries are {cycle[30:0], data bit}.
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  pio_blink_sequencer #(.PATTERN_LEN(LEN), .PERIOD_W(32), .PERIOD_RST(PRST)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
    .pio_writedata(pio_writedata), .step(step)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // PIO monitor
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("pio_write_n_vs_cs", {31'b0, pio_write_n}, {31'b0, ~pio_chipselect});
      chk("pio_address", {30'b0, pio_address}, 32'd0);
      if (pio_chipselect === 1'b1) begin
        chk("pio_writedata_upper", pio_writedata & 32'hFFFF_FFFE, 32'd0);
        obs_q.push_back({cyc[30:0], pio_writedata[0]});
      end
    end
  end

  // driver tasks
  task automatic drive_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    last_wr_cyc = cyc;
  endtask

  task automatic host_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    drive_write(a, d);
  endtask

  task automatic host_write_at(input int target, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    for (int i = 0; i < 2000 && cyc < target - 1; i++) @(negedge clk);
    chk("write_timing", cyc, target - 1);
    drive_write(a, d);
  endtask

  task automatic idle();
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d = readdata;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // reference model: tick k lands at t0+1+eff*k carrying pat[k%LEN]; a manual strobe
  // landing on a tick slot goes first and pushes only that tick back one cycle.
  task automatic build_exp(input int t0, input int eff, input int last_edge, input int man_edge,
                           input logic [7:0] pat, output int nticks, output logic lastb);
    int   t;
    logic b;
    exp_q.delete();
    nticks = 0;
    lastb  = 1'b0;
    for (int k = 0; t0 + 1 + eff * k <= last_edge; k++) begin
      t = t0 + 1 + eff * k;
      b = pat[k % LEN];
      if (t == man_edge + 1) begin
        exp_q.push_back({t[30:0], 1'b1});
        t++;
      end
      exp_q.push_back({t[30:0], b});
      nticks++;
      lastb = b;
    end
  endtask

  task automatic compare_strobes(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_strobe%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  task automatic run_round(input string tag, input int period, input logic [7:0] pat,
                           input bit man, input bit oneshot);
    int          t0;
    int          eff;
    int          last_edge;
    int          man_edge;
    int          nticks;
    logic        lastb;
    logic [31:0] rd;
    eff = (period == 0) ? 1 : period;
    man_edge = -100;
    host_write(2'd1, period);
    host_write(2'd2, {24'b0, pat});
    obs_q.delete();
    host_write(2'd0, oneshot ? 32'd3 : 32'd1);
    t0 = last_wr_cyc;
    idle();
    if (oneshot) begin
      wait_cycles(LEN * eff + 110);
      last_edge = t0 + 1 + eff * (LEN - 1);
    end else begin
      if (man) begin
        man_edge = t0 + 8;
        host_write_at(man_edge, 2'd3, 32'd1);
        idle();
      end
      wait_cycles(7);
      host_write(2'd0, 32'd1);
      idle();
      wait_cycles($urandom_range(40, 60));
      host_write(2'd0, 32'd0);
      last_edge = last_wr_cyc;
      idle();
      wait_cycles(20);
    end
    build_exp(t0, eff, last_edge, man_edge, pat, nticks, lastb);
    compare_strobes(tag);
    read_reg(2'd0, rd);
    chk({tag, "_ctrl"}, rd, oneshot ? 32'd4 : 32'd0);
    read_reg(2'd1, rd);
    chk({tag, "_period"}, rd, period);
    read_reg(2'd3, rd);
    chk({tag, "_status"}, rd, {16'b0, 8'(nticks % LEN), 5'b0, lastb, oneshot, 1'b0});
    chk({tag, "_step_port"}, {24'b0, step}, nticks % LEN);
    idle();
  endtask

  initial begin
    logic [31:0] rd;
    int          t0;
    int          ea;
    logic [7:0]  pat;

    // clock / reset
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    wait_cycles(3);
    reset_n = 1'b1;

    read_reg(2'd1, rd);
    chk("rst_period", rd, PRST);
    read_reg(2'd3, rd);
    chk("rst_manual", rd, 32'd0);
    read_reg(2'd0, rd);
    chk("rst_ctrl", rd, 32'd0);
    read_reg(2'd2, rd);
    chk("rst_pattern", rd, 32'd0);
    chk("rst_pio_cs", {31'b0, pio_chipselect}, 32'd0);
    chk("rst_pio_wn", {31'b0, pio_write_n}, 32'd1);
    chk("rst_step", {24'b0, step}, 32'd0);
    idle();

    run_round("p4_fixed", 4, 8'b1011_0010, 1'b0, 1'b0);
    run_round("p0_rand", 0, 8'($urandom), 1'b0, 1'b0);
    run_round("prand", $urandom_range(1, 6), 8'($urandom), 1'b0, 1'b0);
    run_round("manual_hit", 4, 8'($urandom), 1'b1, 1'b0);
    run_round("one_shot", $urandom_range(0, 3), 8'($urandom), 1'b0, 1'b1);

    // back-to-back manual writes while disabled
    obs_q.delete();
    host_write(2'd3, 32'd0);
    ea = last_wr_cyc;
    host_write(2'd3, 32'd1);
    idle();
    wait_cycles(6);
    exp_q.delete();
    exp_q.push_back({31'(ea + 1), 1'b0});
    exp_q.push_back({31'(ea + 2), 1'b1});
    compare_strobes("manual_b2b");

    // reset while both a tick and a manual write are pending
    pat = 8'($urandom);
    host_write(2'd1, 32'd4);
    host_write(2'd2, {24'b0, pat});
    host_write(2'd0, 32'd1);
    t0 = last_wr_cyc;
    host_write_at(t0 + 8, 2'd3, 32'd1);
    @(negedge clk);
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    #1;
    obs_q.delete();
    chk("mid_rst_pio_cs", {31'b0, pio_chipselect}, 32'd0);
    chk("mid_rst_pio_wn", {31'b0, pio_write_n}, 32'd1);
    chk("mid_rst_pio_data", pio_writedata, 32'd0);
    wait_cycles(3);
    reset_n = 1'b1;
    read_reg(2'd0, rd);
    chk("mid_rst_ctrl", rd, 32'd0);
    read_reg(2'd1, rd);
    chk("mid_rst_period", rd, PRST);
    read_reg(2'd2, rd);
    chk("mid_rst_pattern", rd, 32'd0);
    read_reg(2'd3, rd);
    chk("mid_rst_manual", rd, 32'd0);
    idle();
    wait_cycles(20);
    chk("mid_rst_no_strobe", obs_q.size(), 32'd0);

    // report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
